// File: rtl/h264_coeff_quantiser.sv
// H.264 forward quantiser: serial 4x4 coefficients in, saturated levels out, 3-register pipeline.
// Optional QUANT_NZ_STATS_EN adds NZ_COUNT, the per-block non-zero level count.
module h264_coeff_quantiser #(
  parameter int IN_W   = 14,
  parameter int OUT_W  = 12,
  parameter int QP_MAX = 51
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic signed [IN_W-1:0]  YNIN,
  input  logic        [5:0]       QP,
  input  logic                    INTRA,
  output logic                    VALID,
  output logic signed [OUT_W-1:0] ZOUT,
  output logic        [3:0]       ZIDX,
  output logic                    BLOCK_DONE
`ifdef QUANT_NZ_STATS_EN
  ,
  output logic        [4:0]       NZ_COUNT
`endif
);

  localparam int PROD_W = IN_W + 13;
  localparam int SUM_W  = PROD_W + 1;
  localparam int ZMAX   = (1 << (OUT_W - 1)) - 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [5:0]  qp_clamp;
  logic [3:0]  qp_div6_r;
  logic [2:0]  qp_mod6_r;
  logic        intra_r;
  logic        start;

  assign qp_clamp = (QP > 6'(QP_MAX)) ? 6'(QP_MAX) : QP;
  assign start    = ENABLE && (state == IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (ENABLE) begin
        state_nxt = BUSY;
        cnt_nxt   = 4'd1;
      end
      BUSY: if (ENABLE) begin
        if (cnt == 4'd15) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      qp_div6_r <= '0;
      qp_mod6_r <= '0;
      intra_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start) begin
        qp_div6_r <= 4'(qp_clamp / 6'd6);
        qp_mod6_r <= 3'(qp_clamp % 6'd6);
        intra_r   <= INTRA;
      end
    end
  end

  // Capture register; stage 1 then reads the already-latched QP for idx 0 onwards.
  logic                   s0_valid;
  logic signed [IN_W-1:0] s0_w;
  logic [3:0]             s0_idx;

  logic [IN_W-1:0] mag;
  logic [13:0]     mf;
  logic            s1_valid, s1_neg, s1_intra;
  logic [IN_W-1:0] s1_mag;
  logic [13:0]     s1_mf;
  logic [3:0]      s1_idx, s1_div6;

  assign mag = s0_w[IN_W-1] ? IN_W'(-s0_w) : IN_W'(s0_w);

  always_comb begin
    mf = '0;
    case ({s0_idx[2], s0_idx[0]})
      2'b00: case (qp_mod6_r)
        3'd0: mf = 14'd13107;  3'd1: mf = 14'd11916;  3'd2: mf = 14'd10082;
        3'd3: mf = 14'd9362;   3'd4: mf = 14'd8192;   default: mf = 14'd7282;
      endcase
      2'b11: case (qp_mod6_r)
        3'd0: mf = 14'd5243;   3'd1: mf = 14'd4660;   3'd2: mf = 14'd4194;
        3'd3: mf = 14'd3647;   3'd4: mf = 14'd3355;   default: mf = 14'd2893;
      endcase
      default: case (qp_mod6_r)
        3'd0: mf = 14'd8066;   3'd1: mf = 14'd7490;   3'd2: mf = 14'd6554;
        3'd3: mf = 14'd5825;   3'd4: mf = 14'd5243;   default: mf = 14'd4559;
      endcase
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s0_valid <= 1'b0;
      s0_w     <= '0;
      s0_idx   <= '0;
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_intra <= 1'b0;
      s1_mag   <= '0;
      s1_mf    <= '0;
      s1_idx   <= '0;
      s1_div6  <= '0;
    end else begin
      s0_valid <= ENABLE;
      s0_w     <= YNIN;
      s0_idx   <= cnt;
      s1_valid <= s0_valid;
      s1_neg   <= s0_w[IN_W-1];
      s1_mag   <= mag;
      s1_mf    <= mf;
      s1_idx   <= s0_idx;
      s1_div6  <= qp_div6_r;
      s1_intra <= intra_r;
    end
  end

  logic [4:0]       qbits;
  logic [SUM_W-1:0] f3, f, sum, shifted;
  logic [OUT_W-2:0] z_mag;
  logic signed [OUT_W-1:0] z;

  assign qbits = 5'd15 + {1'b0, s1_div6};
  // floor(2^24/3) = 0x555555; shifting it right gives floor(2^q/3), and halving that gives floor(2^q/6).
  assign f3      = SUM_W'(24'h555555) >> (5'd24 - qbits);
  assign f       = s1_intra ? f3 : (f3 >> 1);
  assign sum     = SUM_W'(PROD_W'(s1_mag) * PROD_W'(s1_mf)) + f;
  assign shifted = sum >> qbits;
  assign z_mag   = (shifted > SUM_W'(ZMAX)) ? (OUT_W-1)'(ZMAX) : shifted[OUT_W-2:0];
  assign z       = s1_neg ? -$signed({1'b0, z_mag}) : $signed({1'b0, z_mag});

  always_ff @(posedge CLK) begin
    if (RESET) begin
      VALID      <= 1'b0;
      ZOUT       <= '0;
      ZIDX       <= '0;
      BLOCK_DONE <= 1'b0;
    end else begin
      VALID      <= s1_valid;
      BLOCK_DONE <= s1_valid && (s1_idx == 4'd15);
      if (s1_valid) begin
        ZOUT <= z;
        ZIDX <= s1_idx;
      end
    end
  end

`ifdef QUANT_NZ_STATS_EN
  logic [4:0] nz_run, nz_nxt;

  assign nz_nxt = ((s1_idx == 4'd0) ? 5'd0 : nz_run) + {4'd0, (z_mag != '0)};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      nz_run   <= '0;
      NZ_COUNT <= '0;
    end else if (s1_valid) begin
      nz_run <= nz_nxt;
      if (s1_idx == 4'd15) NZ_COUNT <= nz_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_h264_coeff_quantiser.sv
// Directed table-driven bench for h264_coeff_quantiser with a timed expectation queue.
module tb_h264_coeff_quantiser;

  logic              CLK = 1'b0;
  logic              RESET, ENABLE, INTRA;
  logic signed [13:0] YNIN;
  logic [5:0]        QP;
  logic              VALID, BLOCK_DONE;
  logic signed [11:0] ZOUT;
  logic [3:0]        ZIDX;
`ifdef QUANT_NZ_STATS_EN
  logic [4:0]        NZ_COUNT;
`endif

  h264_coeff_quantiser #(.IN_W(14), .OUT_W(12), .QP_MAX(51)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .YNIN(YNIN), .QP(QP), .INTRA(INTRA),
    .VALID(VALID), .ZOUT(ZOUT), .ZIDX(ZIDX), .BLOCK_DONE(BLOCK_DONE)
`ifdef QUANT_NZ_STATS_EN
    , .NZ_COUNT(NZ_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct { int qp; bit intra; int w; int idx; int z; bit gap; } vec_t;
  typedef struct { int cyc; int idx; int z; bit done; int nz; } exp_t;

  vec_t tbl[64];
  exp_t q[$];
  int   z1[16] = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 1, 0};
  int   checks = 0, errors = 0, cyc = 0, nz_run = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL valid_missing idx %0d actual 0 required 1 (t=%0t)", e.idx, $time);
    end
    if (VALID) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check("zidx", int'(ZIDX), e.idx);
        check("zout", int'(ZOUT), e.z);
        check("block_done", int'(BLOCK_DONE), int'(e.done));
`ifdef QUANT_NZ_STATS_EN
        if (e.done) check("nz_count", int'(NZ_COUNT), e.nz);
`endif
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual 1 required 0 (t=%0t)", $time);
      end
    end
  end

  // Inputs applied just after an edge are sampled on the next edge; the level is due two edges later.
  task automatic drive(input bit en, input int w, input int qp, input bit intra,
                       input bit push, input int eidx, input int ez);
    exp_t e;
    ENABLE = en; YNIN = 14'(w); QP = 6'(qp); INTRA = intra;
    if (push) begin
      if (eidx == 0) nz_run = 0;
      if (ez != 0) nz_run++;
      e = '{cyc + 3, eidx, ez, (eidx == 15), nz_run};
      q.push_back(e);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    int budget;
    RESET = 1'b1; ENABLE = 1'b0; YNIN = '0; QP = '0; INTRA = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      check("idle_valid", int'(VALID), 0);
      check("idle_zout", int'(ZOUT), 0);
      check("idle_done", int'(BLOCK_DONE), 0);
    end
`ifdef QUANT_NZ_STATS_EN
    check("nz_reset", int'(NZ_COUNT), 0);
`endif
    @(posedge CLK); #1;

    for (int i = 0; i < 16; i++) begin
      tbl[i]      = '{28, 1'b1, 100, i, z1[i], 1'b0};
      tbl[16 + i] = '{0, 1'b1, 0, i, 0, 1'b0};
      tbl[32 + i] = '{60, 1'b0, 0, i, 0, 1'b0};
      tbl[48 + i] = '{12, 1'b0, 0, i, 0, 1'b0};
    end
    tbl[16].w = 8191;   tbl[16].z = 2047;
    tbl[17].w = -8192;  tbl[17].z = -2016;
    tbl[18].w = -8192;  tbl[18].z = -2047;
    tbl[32].w = -100;   tbl[32].z = 0;
    for (int i = 37; i < 48; i++) begin
      tbl[i].qp = 0; tbl[i].intra = 1'b1;
    end
    tbl[37].w = 8191;   tbl[37].z = 3;
    tbl[38].w = 5000;   tbl[38].z = 3;
    tbl[47].w = -8192;  tbl[47].z = -3;
    tbl[35].gap = 1'b1; tbl[40].gap = 1'b1;
    tbl[48].w = -1000;  tbl[48].z = -100;
    tbl[49].w = 1000;   tbl[49].z = 61;
    tbl[50].w = 7;      tbl[50].z = 0;
    tbl[53].w = 1;      tbl[53].z = 0;

    for (int i = 0; i < 64; i++) begin
      drive(1'b1, tbl[i].w, tbl[i].qp, tbl[i].intra, 1'b1, tbl[i].idx, tbl[i].z);
      if (tbl[i].gap) repeat (2) drive(1'b0, 1234, 7, 1'b1, 1'b0, 0, 0);
    end
    repeat (3) drive(1'b0, 0, 28, 1'b1, 1'b0, 0, 0);

    for (int i = 0; i < 8; i++) drive(1'b1, 100, 28, 1'b1, 1'b1, i, z1[i]);
    RESET = 1'b1;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    drive(1'b1, 500, 28, 1'b1, 1'b0, 0, 0);
    RESET = 1'b0;
    for (int i = 0; i < 16; i++) drive(1'b1, 100, 28, 1'b1, 1'b1, i, z1[i]);
    ENABLE = 1'b0;

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge CLK);
      budget++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual %0d pending required 0", q.size());
    end
    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
